// File: rtl/t05_tree_walker_pkg.sv
// Shared types and node-word layout for the Huffman tree walker.
package t05_htree_pkg;
  localparam int NODE_W  = 71;
  localparam int IDX_MSB = 70;
  localparam int IDX_LSB = 64;
  localparam int L1_MSB  = 63;
  localparam int L1_LSB  = 55;
  localparam int L2_MSB  = 54;
  localparam int L2_LSB  = 46;
  localparam int PTR_W   = 9;
  localparam int CODE_W  = 16;
  localparam int LEN_W   = 5;

  // Sum-node tag with an out-of-range index marks an absent child.
  localparam logic [PTR_W-1:0] NULL_PTR = 9'h180;

  typedef enum logic [2:0] {IDLE, PROC, FETCH, EMIT, POP, DONE, ERR} tw_state_t;

  typedef struct packed {
    logic [PTR_W-1:0]  ptr;
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } tw_item_t;

  function automatic logic is_leaf(input logic [PTR_W-1:0] ptr);
    return ~ptr[8];
  endfunction
endpackage

// File: rtl/t05_tree_walker_if.sv
// SRAM read port and codebook output channel of the tree walker.
interface t05_tree_walker_if #(parameter int MAX_LEN = 16);
  import t05_htree_pkg::*;

  logic              rd_req;
  logic [6:0]        rd_addr;
  logic              rd_valid;
  logic [NODE_W-1:0] rd_data;
  logic              cb_valid;
  logic              cb_ready;
  logic [7:0]        cb_char;
  logic [MAX_LEN-1:0] cb_code;
  logic [4:0]        cb_len;

  modport master (
    output rd_req, rd_addr, cb_valid, cb_char, cb_code, cb_len,
    input  rd_valid, rd_data, cb_ready
  );

  modport slave (
    input  rd_req, rd_addr, cb_valid, cb_char, cb_code, cb_len,
    output rd_valid, rd_data, cb_ready
  );
endinterface

// File: rtl/t05_tree_walker_stack.sv
// LIFO of pending right-branch work items for the depth-first walk.
module t05_tw_stack
  import t05_htree_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     push,
  input  logic     pop,
  input  tw_item_t push_item,
  output tw_item_t top_item,
  output logic     full,
  output logic     empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tw_item_t        mem_q [DEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_idx, rd_idx;

  assign wr_idx   = AW'(cnt_q);
  assign rd_idx   = AW'(cnt_q - 1'b1);
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_item = mem_q[rd_idx];

  // Occupancy update; clear wins, push and pop are never issued together.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (push && !full)  cnt_d = cnt_q + 1'b1;
    else if (pop && !empty)  cnt_d = cnt_q - 1'b1;
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem_q[wr_idx] <= push_item;
  end
endmodule

// File: rtl/t05_tree_walker.sv
// Depth-first walker that turns the SRAM Huffman tree into codebook entries.
//
//  state | meaning
//  IDLE  | waiting for start after reset
//  PROC  | classify current item pointer (null / leaf / sum node)
//  FETCH | reading the sum node at rd_addr; split into left item + pushed right item
//  EMIT  | presenting a leaf entry until cb_ready
//  POP   | resume from the stack or finish
//  DONE  | walk complete, waiting for start
//  ERR   | fault seen, waiting for start
module t05_tree_walker
  import t05_htree_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [6:0]         root_idx,
  t05_tree_walker_if.master  bus,
  output logic [7:0]         char_cnt,
  output logic               done,
  output logic               error
);
  tw_state_t          state_q, state_d;
  tw_item_t           item_q, item_d, push_item, top_item;
  logic [7:0]         char_cnt_q, char_cnt_d;
  logic [6:0]         rd_addr_q, rd_addr_d;
  logic [7:0]         cb_char_q, cb_char_d;
  logic [MAX_LEN-1:0] cb_code_q, cb_code_d;
  logic [4:0]         cb_len_q, cb_len_d;
  logic               push, pop, stk_clr, stk_full, stk_empty, start_ok;
  logic [6:0]         node_idx;
  logic [PTR_W-1:0]   node_l1, node_l2;
  logic               unused_sum;

  assign node_idx   = bus.rd_data[IDX_MSB:IDX_LSB];
  assign node_l1    = bus.rd_data[L1_MSB:L1_LSB];
  assign node_l2    = bus.rd_data[L2_MSB:L2_LSB];
  assign unused_sum = ^bus.rd_data[L2_LSB-1:0];
  assign start_ok   = start && (state_q inside {IDLE, DONE, ERR});

  assign push_item = '{ptr:  node_l2,
                       code: {item_q.code[CODE_W-2:0], 1'b1},
                       len:  item_q.len + 1'b1};

  t05_tw_stack #(.DEPTH(MAX_LEN)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (stk_clr),
    .push      (push),
    .pop       (pop),
    .push_item (push_item),
    .top_item  (top_item),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next-state and datapath decisions for the walk.
  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    char_cnt_d = char_cnt_q;
    rd_addr_d  = rd_addr_q;
    cb_char_d  = cb_char_q;
    cb_code_d  = cb_code_q;
    cb_len_d   = cb_len_q;
    push       = 1'b0;
    pop        = 1'b0;
    stk_clr    = 1'b0;
    if (start_ok) begin
      item_d     = '{ptr: {2'b10, root_idx}, code: '0, len: '0};
      char_cnt_d = '0;
      stk_clr    = 1'b1;
      state_d    = PROC;
    end else begin
      case (state_q)
        PROC: begin
          if (item_q.ptr == NULL_PTR) begin
            state_d = POP;
          end else if (is_leaf(item_q.ptr)) begin
            cb_char_d = item_q.ptr[7:0];
            cb_code_d = item_q.code[MAX_LEN-1:0];
            cb_len_d  = item_q.len;
            state_d   = EMIT;
          end else begin
            rd_addr_d = item_q.ptr[6:0];
            state_d   = FETCH;
          end
        end
        FETCH: begin
          if (bus.rd_valid) begin
            if (node_idx != rd_addr_q || item_q.len == LEN_W'(MAX_LEN)) begin
              state_d = ERR;
            end else if (node_l2 != NULL_PTR && stk_full) begin
              state_d = ERR;
            end else begin
              push    = (node_l2 != NULL_PTR);
              item_d  = '{ptr:  node_l1,
                          code: {item_q.code[CODE_W-2:0], 1'b0},
                          len:  item_q.len + 1'b1};
              state_d = PROC;
            end
          end
        end
        EMIT: begin
          if (bus.cb_ready) begin
            char_cnt_d = char_cnt_q + 1'b1;
            state_d    = POP;
          end
        end
        POP: begin
          if (stk_empty) begin
            state_d = DONE;
          end else begin
            item_d  = top_item;
            pop     = 1'b1;
            state_d = PROC;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      item_q     <= '0;
      char_cnt_q <= '0;
      rd_addr_q  <= '0;
      cb_char_q  <= '0;
      cb_code_q  <= '0;
      cb_len_q   <= '0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      char_cnt_q <= char_cnt_d;
      rd_addr_q  <= rd_addr_d;
      cb_char_q  <= cb_char_d;
      cb_code_q  <= cb_code_d;
      cb_len_q   <= cb_len_d;
    end
  end

  assign bus.rd_req   = (state_q == FETCH);
  assign bus.rd_addr  = rd_addr_q;
  assign bus.cb_valid = (state_q == EMIT);
  assign bus.cb_char  = cb_char_q;
  assign bus.cb_code  = cb_code_q;
  assign bus.cb_len   = cb_len_q;
  assign char_cnt     = char_cnt_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
endmodule

// File: tb/tb_t05_tree_walker.sv
// Bench for the tree walker: directed trees plus random trees against a codebook model.
module tb_t05_tree_walker;
  import t05_htree_pkg::*;

  typedef struct packed {
    logic [7:0]  ch;
    logic [15:0] code;
    logic [4:0]  len;
  } ent_t;

  typedef struct packed {
    logic [8:0]  ptr;
    logic [15:0] code;
    logic [4:0]  len;
  } work_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] root_idx;
  logic [7:0] char_cnt;
  logic       done;
  logic       error;

  t05_tree_walker_if #(.MAX_LEN(16)) bus ();

  t05_tree_walker #(.MAX_LEN(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .root_idx (root_idx),
    .bus      (bus),
    .char_cnt (char_cnt),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  logic [NODE_W-1:0] mem [128];
  ent_t got_q[$];
  ent_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   n_fetch = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {bus.rd_req, bus.cb_valid, done, error, bus.rd_addr,
            bus.cb_char, bus.cb_code, bus.cb_len, char_cnt};
  endfunction

  function automatic logic [NODE_W-1:0] node(input logic [6:0] idx,
                                             input logic [8:0] l1, input logic [8:0] l2);
    return {idx, l1, l2, 46'(idx) + 46'd3};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = '0;
  endtask

  task automatic exp_add(input logic [7:0] ch, input logic [15:0] code, input logic [4:0] len);
    exp_q.push_back('{ch, code, len});
  endtask

  // Codebook order: pre-order with 0 before 1 equals ascending left-aligned codes.
  function automatic logic [15:0] key(input ent_t e);
    return e.code << (5'd16 - e.len);
  endfunction

  task automatic model_walk(input logic [6:0] root);
    work_t wl[$];
    work_t w;
    ent_t  t;
    logic [NODE_W-1:0] n;
    exp_q.delete();
    wl.push_back('{{2'b10, root}, 16'd0, 5'd0});
    while (wl.size() > 0) begin
      w = wl.pop_back();
      if (w.ptr == NULL_PTR) continue;
      if (!w.ptr[8]) begin
        exp_q.push_back('{w.ptr[7:0], w.code, w.len});
      end else begin
        n = mem[w.ptr[6:0]];
        wl.push_back('{n[63:55], {w.code[14:0], 1'b0}, w.len + 5'd1});
        wl.push_back('{n[54:46], {w.code[14:0], 1'b1}, w.len + 5'd1});
      end
    end
    for (int i = 1; i < exp_q.size(); i++) begin
      for (int j = i; j > 0 && key(exp_q[j-1]) > key(exp_q[j]); j--) begin
        t = exp_q[j]; exp_q[j] = exp_q[j-1]; exp_q[j-1] = t;
      end
    end
  endtask

  task automatic gen_tree(output logic [6:0] root);
    int pend_idx[$];
    int pend_d[$];
    int n, idx, d, r;
    logic [6:0] base;
    logic [8:0] ch [2];
    clear_mem();
    base = 7'($urandom_range(0, 127));
    root = base;
    pend_idx.push_back(int'(base));
    pend_d.push_back(0);
    n = 1;
    while (pend_idx.size() > 0) begin
      idx = pend_idx.pop_front();
      d   = pend_d.pop_front();
      for (int k = 0; k < 2; k++) begin
        r = int'($urandom_range(0, 9));
        if (r == 9) begin
          ch[k] = NULL_PTR;
        end else if (r < 5 && d < 14 && n < 24) begin
          ch[k] = {2'b10, 7'(int'(base) + n)};
          pend_idx.push_back(int'(7'(int'(base) + n)));
          pend_d.push_back(d + 1);
          n++;
        end else begin
          ch[k] = {1'b0, 8'($urandom)};
        end
      end
      mem[idx] = {7'(idx), ch[0], ch[1], 46'($urandom)};
    end
  endtask

  task automatic kick(input logic [6:0] r);
    @(negedge clk);
    root_idx = r;
    start    = 1'b1;
  endtask

  // Plays SRAM and codebook writer until done/error or the cycle budget runs out.
  // stall_mode: 0 = accept at once, 1 = hold cb_ready low 5 cycles, 2 = random stalls.
  task automatic run_walk(input int stall_mode, input bit rnd, input bit busy_start,
                          input int max_cycles);
    bit finished = 0, req_active = 0, ent_active = 0, did_start = 0;
    int lat = 0, stall = 0;
    logic [6:0] req_addr = '0;
    ent_t snap, cur;
    got_q.delete();
    n_fetch = 0;
    for (int cyc = 0; cyc < max_cycles && !finished; cyc++) begin
      @(negedge clk);
      start        = 1'b0;
      bus.rd_valid = 1'b0;
      bus.cb_ready = 1'b0;
      if (done || error) begin
        finished = 1;
      end else begin
        if (bus.rd_req) begin
          if (!req_active) begin
            req_active = 1;
            req_addr   = bus.rd_addr;
            lat        = rnd ? int'($urandom_range(0, 3)) : 0;
          end else begin
            check("rd_addr_stable", 64'(bus.rd_addr), 64'(req_addr));
          end
          if (lat == 0) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = mem[bus.rd_addr];
            req_active   = 0;
            n_fetch++;
          end else begin
            lat--;
          end
        end else if (rnd && $urandom_range(0, 7) == 0) begin
          bus.rd_valid = 1'b1;
          bus.rd_data  = NODE_W'({$urandom, $urandom, $urandom});
        end
        cur = '{bus.cb_char, bus.cb_code, bus.cb_len};
        if (bus.cb_valid) begin
          if (!ent_active) begin
            ent_active = 1;
            snap  = cur;
            stall = (stall_mode == 1) ? 5 :
                    (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            if (busy_start && !did_start) begin
              did_start = 1;
              start     = 1'b1;
              root_idx  = 7'd100;
            end
          end else begin
            check("cb_stable", 64'(cur), 64'(snap));
          end
          if (stall == 0) begin
            bus.cb_ready = 1'b1;
            got_q.push_back(cur);
            ent_active = 0;
          end else begin
            stall--;
          end
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          bus.cb_ready = 1'b1;
        end
      end
    end
    check("walk_finished", 64'(finished), 64'd1);
  endtask

  task automatic check_walk(input string tag, input bit exp_done, input bit exp_err);
    check({tag, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s.entry%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, ".char_cnt"}, 64'(char_cnt), 64'(exp_q.size() % 256));
    check({tag, ".done_err"}, 64'({done, error}), 64'({exp_done, exp_err}));
  endtask

  task automatic check_quiet(input string tag);
    repeat (5) begin
      @(negedge clk);
      check(tag, 64'({bus.rd_req, bus.cb_valid, error}), 64'(3'b001));
    end
  endtask

  initial begin
    logic [6:0] r;
    int waited;
    rst_n        = 1'b0;
    start        = 1'b0;
    root_idx     = '0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    bus.cb_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_outs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tree 1: two leaves under the root.
    mem[0] = node(7'd0, 9'h041, 9'h042);
    exp_q.delete();
    exp_add(8'h41, 16'd0, 5'd1);
    exp_add(8'h42, 16'd1, 5'd1);
    kick(7'd0);
    run_walk(0, 0, 0, 200);
    check_walk("t1", 1, 0);

    // Tree 2: nested left subtree.
    mem[1] = node(7'd1, 9'h100, 9'h043);
    exp_q.delete();
    exp_add(8'h41, 16'b00, 5'd2);
    exp_add(8'h42, 16'b01, 5'd2);
    exp_add(8'h43, 16'b1, 5'd1);
    kick(7'd1);
    run_walk(0, 0, 0, 200);
    check_walk("t2", 1, 0);

    // Tree 2 with 5-cycle stalls and a start pulse while busy.
    kick(7'd1);
    run_walk(1, 0, 1, 400);
    check_walk("t3", 1, 0);

    // Reset during the first fetch, then a clean rerun of tree 1.
    kick(7'd1);
    waited = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      waited++;
    end while (!bus.rd_req && waited < 20);
    check("t6_fetch_seen", 64'(bus.rd_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outs", 64'(outs()), 64'd0);
    bus.rd_valid = 1'b1;
    bus.rd_data  = mem[1];
    bus.cb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_reset_held", 64'(outs()), 64'd0);
    bus.rd_valid = 1'b0;
    bus.cb_ready = 1'b0;
    rst_n = 1'b1;
    clear_mem();
    mem[0] = node(7'd0, 9'h041, 9'h042);
    exp_q.delete();
    exp_add(8'h41, 16'd0, 5'd1);
    exp_add(8'h42, 16'd1, 5'd1);
    kick(7'd0);
    run_walk(0, 0, 0, 200);
    check_walk("t6_rerun", 1, 0);

    // Root with only a left leaf.
    mem[0] = node(7'd0, 9'h041, NULL_PTR);
    exp_q.delete();
    exp_add(8'h41, 16'd0, 5'd1);
    kick(7'd0);
    run_walk(0, 0, 0, 200);
    check_walk("t4", 1, 0);

    // Root with no children.
    mem[0] = node(7'd0, NULL_PTR, NULL_PTR);
    exp_q.delete();
    kick(7'd0);
    run_walk(0, 0, 0, 200);
    check_walk("t_empty", 1, 0);

    // Chain one level too deep: the 17th fetch faults.
    clear_mem();
    for (int k = 0; k < 17; k++)
      mem[k] = node(7'(k), (k < 16) ? {2'b10, 7'(k + 1)} : 9'h05A, NULL_PTR);
    exp_q.delete();
    kick(7'd0);
    run_walk(0, 1, 0, 600);
    check_walk("t5_depth", 0, 1);
    check("t5_fetches", 64'(n_fetch), 64'd17);
    check_quiet("t5_depth_quiet");

    // Chain of exactly full depth: leaves at length 16 are legal.
    clear_mem();
    for (int k = 0; k < 16; k++)
      mem[k] = node(7'(k), (k < 15) ? {2'b10, 7'(k + 1)} : 9'h05A,
                    (k < 15) ? NULL_PTR : 9'h059);
    exp_q.delete();
    exp_add(8'h5A, 16'd0, 5'd16);
    exp_add(8'h59, 16'd1, 5'd16);
    kick(7'd0);
    run_walk(0, 1, 0, 600);
    check_walk("t5_maxlen", 1, 0);

    // Node word at address 2 carries index 3.
    clear_mem();
    mem[5] = node(7'd5, 9'h041, 9'h102);
    mem[2] = node(7'd3, 9'h042, 9'h043);
    exp_q.delete();
    exp_add(8'h41, 16'd0, 5'd1);
    kick(7'd5);
    run_walk(0, 0, 0, 200);
    check_walk("t5_index", 0, 1);
    check_quiet("t5_index_quiet");

    // Random trees with random read latency, stalls and stray handshakes.
    for (int t = 0; t < 10; t++) begin
      gen_tree(r);
      model_walk(r);
      kick(r);
      run_walk(2, 1, (t == 0), 4000);
      check_walk($sformatf("rand%0d", t), 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
